// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg: shared vector-unit types, sizes and the writeback beat record
package riscv_v_pkg;
  localparam int RISCV_V_NUM_BYTES_DATA = 16;
  localparam int RISCV_V_NUM_VREGS = 32;
  localparam int RISCV_V_VREG_ADDR_WIDTH = 5;
  typedef enum logic [2:0] {
    RISCV_V_OSIZE_8,
    RISCV_V_OSIZE_16,
    RISCV_V_OSIZE_32,
    RISCV_V_OSIZE_64,
    RISCV_V_OSIZE_128
  } riscv_v_osize_e;
  typedef logic [8*RISCV_V_NUM_BYTES_DATA-1:0] riscv_v_data_t;
  // osize is kept raw so out-of-range encodings survive into the merge
  typedef struct packed {
    logic [RISCV_V_VREG_ADDR_WIDTH-1:0] addr;
    riscv_v_data_t data;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_valid;
    logic [2:0] osize;
    logic is_mask;
  } riscv_v_wb_beat_t;
endpackage

// File: rtl/riscv_v_wb_merge.sv
// riscv_v_wb_merge: combinational byte merge / compare-bit mask packing onto old vd
module riscv_v_wb_merge import riscv_v_pkg::*; #(
  parameter int NB = RISCV_V_NUM_BYTES_DATA
) (
  input  logic [8*NB-1:0] i_old,
  input  logic [8*NB-1:0] i_result,
  input  logic [NB-1:0]   i_byte_valid,
  input  logic [2:0]      i_osize,
  input  logic            i_is_mask,
  output logic [8*NB-1:0] o_merged
);
  localparam int BW = $clog2(NB);
  logic w_ok;
  assign w_ok = i_osize <= 3'(RISCV_V_OSIZE_128);
  // mask bit i takes the LSB of element i, gated by that element's first byte
  always_comb begin
    logic [BW-1:0] w_eb;
    w_eb = '0;
    o_merged = i_old;
    for (int i = 0; i < NB; i++) begin
      w_eb = BW'(i << i_osize);
      if (w_ok && !i_is_mask && i_byte_valid[i]) o_merged[8*i +: 8] = i_result[8*i +: 8];
      if (w_ok && i_is_mask && (i < (NB >> i_osize)) && i_byte_valid[w_eb]) o_merged[i] = i_result[{w_eb, 3'b000}];
    end
  end
endmodule

// File: rtl/riscv_v_writeback_element.sv
// riscv_v_writeback_element: accept / read-merge / write pipeline into the vector
// register file, with S2->S1 same-register forwarding and a write-port stall.
module riscv_v_writeback_element import riscv_v_pkg::*; #(
  parameter int NUM_BYTES_DATA = RISCV_V_NUM_BYTES_DATA,
  parameter int NUM_VREGS = RISCV_V_NUM_VREGS,
  parameter int ADDR_WIDTH = RISCV_V_VREG_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_vd_addr,
  input  logic [8*NUM_BYTES_DATA-1:0] in_result,
  input  logic [NUM_BYTES_DATA-1:0]   in_byte_valid,
  input  logic [2:0]                  in_osize,
  input  logic                        in_is_mask,
  output logic [ADDR_WIDTH-1:0]       rf_rd_addr,
  input  logic [8*NUM_BYTES_DATA-1:0] rf_rd_data,
  input  logic                        wb_stall,
  output logic                        rf_we,
  output logic [ADDR_WIDTH-1:0]       rf_wr_addr,
  output logic [8*NUM_BYTES_DATA-1:0] rf_wr_data,
  output logic [NUM_VREGS-1:0]        vd_busy
);
  logic r_s1_v, r_s2_v;
  riscv_v_wb_beat_t r_s1;
  logic [ADDR_WIDTH-1:0] r_s2_addr;
  logic [8*NUM_BYTES_DATA-1:0] r_s2_data, w_old, w_merged;
  logic w_fwd;
  assign in_ready = ~wb_stall;
  // while stalled, re-read S1's vd so the data is fresh on release
  assign rf_rd_addr = wb_stall ? r_s1.addr : in_vd_addr;
  assign rf_we = r_s2_v & ~wb_stall;
  assign rf_wr_addr = r_s2_addr;
  assign rf_wr_data = r_s2_data;
  assign w_fwd = rf_we && (rf_wr_addr == r_s1.addr);
  assign w_old = w_fwd ? rf_wr_data : rf_rd_data;
  riscv_v_wb_merge #(.NB(NUM_BYTES_DATA)) u_merge (
    .i_old(w_old),
    .i_result(r_s1.data),
    .i_byte_valid(r_s1.byte_valid),
    .i_osize(r_s1.osize),
    .i_is_mask(r_s1.is_mask),
    .o_merged(w_merged)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s1 <= '0;
      r_s2_addr <= '0;
      r_s2_data <= '0;
    end else if (!wb_stall) begin
      r_s1_v <= in_valid;
      if (in_valid) r_s1 <= '{addr: in_vd_addr, data: in_result, byte_valid: in_byte_valid, osize: in_osize, is_mask: in_is_mask};
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_addr <= r_s1.addr;
        r_s2_data <= w_merged;
      end
    end
  end
  always_comb begin
    vd_busy = '0;
    if (r_s1_v) vd_busy[r_s1.addr] = 1'b1;
    if (r_s2_v) vd_busy[r_s2_addr] = 1'b1;
  end
endmodule

// File: tb/tb_riscv_v_writeback_element.sv
// tb_riscv_v_writeback_element: directed vector table plus forwarding/stall/reset sequences
module tb_riscv_v_writeback_element;
  logic clk, rst, in_valid, in_ready, in_is_mask, wb_stall, rf_we;
  logic [4:0] in_vd_addr, rf_rd_addr, rf_wr_addr;
  logic [127:0] in_result, rf_rd_data, rf_wr_data;
  logic [15:0] in_byte_valid;
  logic [2:0] in_osize;
  logic [31:0] vd_busy;
  logic [127:0] mem [32];
  logic tb_we;
  logic [4:0] tb_addr;
  logic [127:0] tb_data;
  int errors = 0, checks = 0;

  typedef struct {
    logic [4:0] addr;
    logic [127:0] old;
    logic [127:0] res;
    logic [15:0] bv;
    logic [2:0] osz;
    logic msk;
    logic [127:0] exp;
  } vec_t;
  vec_t v [9];

  riscv_v_writeback_element dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vd_addr(in_vd_addr), .in_result(in_result), .in_byte_valid(in_byte_valid),
    .in_osize(in_osize), .in_is_mask(in_is_mask), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .wb_stall(wb_stall), .rf_we(rf_we),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .vd_busy(vd_busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // register file with one-cycle read latency
  always @(posedge clk) begin
    rf_rd_data <= mem[rf_rd_addr];
    if (rf_we) mem[rf_wr_addr] <= rf_wr_data;
    if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [127:0] d);
    tb_we = 1; tb_addr = a; tb_data = d;
    tick();
    tb_we = 0;
  endtask

  task automatic beat(input logic [4:0] a, input logic [127:0] r, input logic [15:0] b, input logic [2:0] o, input logic m);
    in_valid = 1; in_vd_addr = a; in_result = r; in_byte_valid = b; in_osize = o; in_is_mask = m;
  endtask

  initial begin
    v[0] = '{5'd3, {16{8'hAA}}, {16{8'h55}}, 16'h00FF, 3'd0, 1'b0, {{8{8'hAA}}, {8{8'h55}}}};
    v[1] = '{5'd4, 128'hFFF0, 128'h00000001_00000001_00000000_00000001, 16'hFFFF, 3'd2, 1'b1, 128'hFFFD};
    v[2] = '{5'd1, 128'h0123456789ABCDEF_FEDCBA9876543210, {16{8'hFF}}, 16'h0000, 3'd0, 1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210};
    v[3] = '{5'd2, {16{8'h22}}, {16{8'h11}}, 16'hFFFF, 3'd5, 1'b0, {16{8'h22}}};
    v[4] = '{5'd6, 128'h5, {16{8'hFF}}, 16'hFFFF, 3'd7, 1'b1, 128'h5};
    v[5] = '{5'd7, 128'hDEAD_0000, {16{8'h03}}, 16'h0F0F, 3'd0, 1'b1, 128'hDEAD_0F0F};
    v[6] = '{5'd12, ~128'h0, 128'h1, 16'hFF00, 3'd3, 1'b1, ~128'h2};
    v[7] = '{5'd13, ~128'h0, 128'h2, 16'h0001, 3'd4, 1'b1, ~128'h1};
    v[8] = '{5'd31, 128'h0, {16{8'hC3}}, 16'h8001, 3'd4, 1'b0, 128'hC3000000_00000000_00000000_000000C3};
    rst = 1; in_valid = 0; wb_stall = 0; tb_we = 0; tb_addr = 0; tb_data = 0;
    beat(5'd0, 128'h0, 16'h0, 3'd0, 1'b0);
    in_valid = 0;
    tick();
    tick();
    rst = 0;
    #1;
    check("reset rf_we", 128'(rf_we), 128'h0);
    check("reset vd_busy", 128'(vd_busy), 128'h0);
    check("reset wr_addr", 128'(rf_wr_addr), 128'h0);
    check("reset wr_data", rf_wr_data, 128'h0);
    check("reset in_ready", 128'(in_ready), 128'h1);

    for (int i = 0; i < 9; i++) begin
      preload(v[i].addr, v[i].old);
      beat(v[i].addr, v[i].res, v[i].bv, v[i].osz, v[i].msk);
      #1;
      check($sformatf("v%0d rd_addr", i), 128'(rf_rd_addr), 128'(v[i].addr));
      tick();
      in_valid = 0;
      check($sformatf("v%0d T+1 we", i), 128'(rf_we), 128'h0);
      check($sformatf("v%0d T+1 busy", i), 128'(vd_busy), 128'(32'd1 << v[i].addr));
      tick();
      check($sformatf("v%0d T+2 we", i), 128'(rf_we), 128'h1);
      check($sformatf("v%0d T+2 addr", i), 128'(rf_wr_addr), 128'(v[i].addr));
      check($sformatf("v%0d T+2 data", i), rf_wr_data, v[i].exp);
      check($sformatf("v%0d T+2 busy", i), 128'(vd_busy), 128'(32'd1 << v[i].addr));
      tick();
      check($sformatf("v%0d T+3 we", i), 128'(rf_we), 128'h0);
      check($sformatf("v%0d T+3 busy", i), 128'(vd_busy), 128'h0);
    end

    // three back-to-back beats to vd5, register file stays stale
    preload(5'd5, 128'h0);
    beat(5'd5, {16{8'h11}}, 16'h0001, 3'd0, 1'b0);
    tick();
    beat(5'd5, {16{8'h22}}, 16'h0002, 3'd0, 1'b0);
    tick();
    beat(5'd5, {16{8'h33}}, 16'h0004, 3'd0, 1'b0);
    check("fwd1 we", 128'(rf_we), 128'h1);
    check("fwd1 data", rf_wr_data, 128'h11);
    tick();
    in_valid = 0;
    check("fwd2 we", 128'(rf_we), 128'h1);
    check("fwd2 data", rf_wr_data, 128'h2211);
    tick();
    check("fwd3 we", 128'(rf_we), 128'h1);
    check("fwd3 addr", 128'(rf_wr_addr), 128'h5);
    check("fwd3 data", rf_wr_data, 128'h332211);
    tick();
    check("fwd done we", 128'(rf_we), 128'h0);

    // stall three cycles with S1 and S2 both holding beats to vd8
    preload(5'd8, 128'h0);
    beat(5'd8, {16{8'hA1}}, 16'hFFFF, 3'd0, 1'b0);
    tick();
    beat(5'd8, {16{8'hB2}}, 16'h00FF, 3'd0, 1'b0);
    tick();
    in_valid = 0;
    wb_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d we", k), 128'(rf_we), 128'h0);
      check($sformatf("stall%0d ready", k), 128'(in_ready), 128'h0);
      check($sformatf("stall%0d rd_addr", k), 128'(rf_rd_addr), 128'h8);
      check($sformatf("stall%0d busy", k), 128'(vd_busy), 128'h100);
      tick();
    end
    wb_stall = 0;
    #1;
    check("release A we", 128'(rf_we), 128'h1);
    check("release A data", rf_wr_data, {16{8'hA1}});
    tick();
    check("release B we", 128'(rf_we), 128'h1);
    check("release B data", rf_wr_data, {{8{8'hA1}}, {8{8'hB2}}});
    tick();
    check("release done we", 128'(rf_we), 128'h0);

    // reset while S1 and S2 are occupied
    preload(5'd10, 128'h0);
    beat(5'd10, {16{8'h77}}, 16'hFFFF, 3'd0, 1'b0);
    tick();
    beat(5'd11, {16{8'h88}}, 16'hFFFF, 3'd0, 1'b0);
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d we", k), 128'(rf_we), 128'h0);
      check($sformatf("rst%0d busy", k), 128'(vd_busy), 128'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
